m_issue_ctrl: RTL and testbench
===============================

Name: m_issue_ctrl

Overview:
Core-side initiator for the riscv_m_unit valid/ready interface. It takes decoded instructions from the core decode stage and detects M-extension and custom modular-arithmetic ops (ADDMOD/SUBMOD/MODQ). For each such op it issues one request to the M unit, stalls the pipeline while the op is outstanding, and writes the result back to the register file. It also handles flush, a response watchdog and an issue counter.

Parameters:
TIMEOUT_CYCLES, 64, max cycles from m_valid pulse to m_ready before a timeout is declared (≥2)
CNT_W, 16, width of issued-operation counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
dec_valid  in  1  decode stage presents an instruction
dec_instruction  in  32  raw instruction word
dec_rs1_val  in  32  rs1 operand value
dec_rs2_val  in  32  rs2 operand value
flush  in  1  pipeline flush; discard outstanding result
stall  out  1  hold decode stage
m_valid  out  1  request strobe to M unit (one-cycle pulse)
m_instruction  out  32  instruction to M unit
m_rs1  out  32  operand 1 to M unit
m_rs2  out  32  operand 2 to M unit
m_wr  in  1  M unit result is to be written
m_rd  in  32  M unit result
m_busy  in  1  M unit busy
m_ready  in  1  M unit result valid (one-cycle)
rf_we  out  1  register-file write enable (one-cycle pulse)
rf_waddr  out  5  destination register
rf_wdata  out  32  write data
err_timeout  out  1  sticky watchdog error
issued_cnt  out  CNT_W  number of ops issued, wraps

Behaviour:
- Match when dec_valid, funct7=7'b0000001, and opcode is OPCODE (any func3) or OPCODE_CUSTOM with func3 in {ADDMOD, SUBMOD, MODQ}. Use the shared definitions header for these values. Non-matching words are ignored and stall stays 0.
- Reset: all outputs 0 and state IDLE. Reset mid-operation abandons the op without a writeback. Any later m_ready is ignored until a new issue.
- States:
  - IDLE: on a match, latch instruction, rs1, rs2 and rd=[11:7]; go to ISSUE. stall is 1 combinationally in the match cycle.
  - ISSUE: if m_busy=1, wait here. Otherwise drive m_valid=1 for exactly one cycle, increment issued_cnt, clear the watchdog counter and go to WAIT. m_instruction, m_rs1 and m_rs2 are registered and stay stable from ISSUE until the op completes.
  - WAIT: on m_ready, capture m_rd and m_wr, then go to WB.
  - WB: if m_wr=1, not flushed and rd≠0, pulse rf_we=1 with rf_waddr=rd and rf_wdata=captured value. Return to IDLE.
- stall is 1 in ISSUE, WAIT and WB, and 0 in IDLE except in the match cycle.
- Minimum latency: match cycle T, m_valid at T+1, rf_we one cycle after m_ready. stall drops in the cycle after WB, so a new match is possible from that cycle.
- Flush:
  - In ISSUE: return to IDLE with no request.
  - In WAIT: set a discard flag, keep waiting for m_ready, then pass through WB with rf_we suppressed (the unit must drain).
  - In IDLE or WB: no effect on a write already in progress.
- Watchdog: counts WAIT cycles. When it reaches TIMEOUT_CYCLES without m_ready: set err_timeout (sticky, cleared only by reset), go to IDLE, no writeback.
- m_ready in the same cycle as the timeout: m_ready wins, normal WB, no error.
- m_ready while not in WAIT is ignored.
- rd=x0 never writes.
- issued_cnt wraps from 2^CNT_W-1 to 0.

Test Plan:
- MUL x5, rs1=0x1111FFFF, rs2=0x1111FFFF; model returns 0xDDDC0001 after 3 cycles -> m_valid is exactly one cycle, stall is held throughout, one rf_we with waddr=5 and wdata=0xDDDC0001, issued_cnt=1.
- DIV x7, 0xFFFFFFF3/0x00000000, with m_busy held high 4 cycles after the match -> m_valid only after m_busy falls; rf_wdata=0xFFFFFFFF.
- Back-to-back MULHU (0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE) then REMU (13%5 -> 3) -> two separate issues, results written to the correct rd in order, no overlap of m_valid.
- Flush asserted in WAIT of ADDMOD -> m_ready still consumed, rf_we stays 0, next op proceeds normally. MUL x0 -> no rf_we.
- TIMEOUT_CYCLES=8, model never raises m_ready -> err_timeout=1 after 8 WAIT cycles, stall=0, no rf_we; late m_ready is ignored.
- Reset pulsed mid-WAIT -> all outputs 0 next cycle; a following MODQ op completes normally; non-M instruction (opcode 0x13) -> no stall, no m_valid.

Source files
------------

// File: rtl/m_issue_ctrl.sv
// m_issue_ctrl: core-side initiator for the riscv_m_unit valid/ready interface.
//
// Watches the decode stage for M-extension ops (OP opcode, funct7=0000001) and
// for the custom modular ops ADDMOD/SUBMOD/MODQ (custom-0 opcode). For each
// match it latches the operands, issues one request to the M unit, holds the
// decode stage with stall while the op is outstanding, and writes the result
// back to the register file.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   dec_*                 decoded instruction and operand values from decode
//   flush                 pipeline flush; outstanding result is discarded
//   stall                 hold decode stage
//   m_valid/m_instruction/m_rs1/m_rs2   request to the M unit
//   m_wr/m_rd/m_busy/m_ready            response/status from the M unit
//   rf_we/rf_waddr/rf_wdata             register-file write port (1-cycle pulse)
//   err_timeout           sticky response-watchdog error
//   issued_cnt            wrapping count of issued requests
module m_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [31:0]      dec_instruction,
  input  logic [31:0]      dec_rs1_val,
  input  logic [31:0]      dec_rs2_val,
  input  logic             flush,
  output logic             stall,
  output logic             m_valid,
  output logic [31:0]      m_instruction,
  output logic [31:0]      m_rs1,
  output logic [31:0]      m_rs2,
  input  logic             m_wr,
  input  logic [31:0]      m_rd,
  input  logic             m_busy,
  input  logic             m_ready,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             err_timeout,
  output logic [CNT_W-1:0] issued_cnt
);

  // Encodings shared with the M unit (standard OP opcode, custom-0 opcode).
  localparam logic [6:0] OPCODE        = 7'b0110011;
  localparam logic [6:0] OPCODE_CUSTOM = 7'b0001011;
  localparam logic [6:0] FUNCT7_M      = 7'b0000001;
  localparam logic [2:0] F3_ADDMOD     = 3'b000;
  localparam logic [2:0] F3_SUBMOD     = 3'b001;
  localparam logic [2:0] F3_MODQ       = 3'b010;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       rs1_q, rs1_d;
  logic [31:0]       rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       res_q, res_d;
  logic              wr_q, wr_d;
  logic              discard_q, discard_d;
  logic              err_q, err_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [6:0] dec_opc;
  logic [2:0] dec_f3;
  logic       custom_f3;
  logic       match;

  assign dec_opc   = dec_instruction[6:0];
  assign dec_f3    = dec_instruction[14:12];
  assign custom_f3 = (dec_f3 == F3_ADDMOD) || (dec_f3 == F3_SUBMOD) || (dec_f3 == F3_MODQ);
  assign match     = dec_valid && (dec_instruction[31:25] == FUNCT7_M) &&
                     ((dec_opc == OPCODE) || ((dec_opc == OPCODE_CUSTOM) && custom_f3));

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    res_d     = res_q;
    wr_d      = wr_q;
    discard_d = discard_q;
    err_d     = err_q;
    wdog_d    = wdog_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    m_valid   = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = 5'd0;
    rf_wdata  = 32'd0;

    unique case (state_q)
      S_IDLE: begin
        if (match) begin
          stall     = 1'b1;
          instr_d   = dec_instruction;
          rs1_d     = dec_rs1_val;
          rs2_d     = dec_rs2_val;
          rd_d      = dec_instruction[11:7];
          discard_d = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        stall = 1'b1;
        // A flush here cancels the op before anything reaches the unit.
        if (flush) begin
          state_d = S_IDLE;
        end else if (!m_busy) begin
          m_valid = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          wdog_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        // The request is already in flight, so the unit must still drain;
        // remember to drop the result instead of leaving early.
        if (flush) begin
          discard_d = 1'b1;
        end
        // A response arriving in the last watchdog cycle still counts.
        if (m_ready) begin
          res_d   = m_rd;
          wr_d    = m_wr;
          state_d = S_WB;
        end else if (wdog_q >= WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_WB: begin
        stall = 1'b1;
        if (wr_q && !discard_q && (rd_q != 5'd0)) begin
          rf_we    = 1'b1;
          rf_waddr = rd_q;
          rf_wdata = res_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      wr_q      <= 1'b0;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
      wdog_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      res_q     <= res_d;
      wr_q      <= wr_d;
      discard_q <= discard_d;
      err_q     <= err_d;
      wdog_q    <= wdog_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m_instruction = instr_q;
  assign m_rs1         = rs1_q;
  assign m_rs2         = rs2_q;
  assign err_timeout   = err_q;
  assign issued_cnt    = cnt_q;

endmodule

// File: tb/tb_m_issue_ctrl.sv
// Self-checking bench for m_issue_ctrl. A behavioural M-unit model answers
// requests with arithmetically computed results; expectations for timing,
// writeback and counters are derived from the controller's contract.
module tb_m_issue_ctrl;

  localparam int TO = 8;
  localparam int CW = 4;
  localparam logic [6:0] OP_M  = 7'h33;
  localparam logic [6:0] OP_CU = 7'h0B;

  logic          clk = 1'b0;
  logic          reset;
  logic          dec_valid;
  logic [31:0]   dec_instruction, dec_rs1_val, dec_rs2_val;
  logic          flush, stall, m_valid;
  logic [31:0]   m_instruction, m_rs1, m_rs2;
  logic          m_wr, m_busy, m_ready;
  logic [31:0]   m_rd;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          err_timeout;
  logic [CW-1:0] issued_cnt;

  always #5 clk = ~clk;

  m_issue_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_instruction(dec_instruction),
    .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val), .flush(flush), .stall(stall),
    .m_valid(m_valid), .m_instruction(m_instruction), .m_rs1(m_rs1), .m_rs2(m_rs2),
    .m_wr(m_wr), .m_rd(m_rd), .m_busy(m_busy), .m_ready(m_ready), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .err_timeout(err_timeout), .issued_cnt(issued_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  // Observations from the last do_op transaction.
  int          obs_mv_cnt, obs_mv_cyc, obs_we_cnt, obs_we_cyc;
  logic [31:0] obs_mi, obs_m1, obs_m2, obs_wdata;
  logic [4:0]  obs_waddr;
  logic        obs_stall_ok, obs_stall_end;

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  // Behavioural M unit: what the unit returns for a given request.
  function automatic logic [31:0] ref_unit(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    r = 32'd0;
    if (instr[6:0] == OP_CU) begin
      case (instr[14:12])
        3'd0:    r = a + b;
        3'd1:    r = a - b;
        default: r = a % 32'd3329;
      endcase
    end else begin
      case (instr[14:12])
        3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
        3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
        3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = p[63:32]; end
        3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
        3'd4: begin
          if (b == 0) r = 32'hFFFFFFFF;
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
          else r = $signed(a) / $signed(b);
        end
        3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
        3'd6: begin
          if (b == 0) r = a;
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
          else r = $signed(a) % $signed(b);
        end
        default: r = (b == 0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  // Runs one op: match in cycle 0, m_busy high in cycles 1..busy_n, the unit
  // answers lat cycles after m_valid, optional flush in the first WAIT cycle.
  task automatic do_op(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                       input int busy_n, input int lat, input logic wr, input logic flush_wait);
    int mvc;
    int end_cyc;
    logic [31:0] res;
    res = ref_unit(instr, a, b);
    mvc = -1; end_cyc = 1000;
    obs_mv_cnt = 0; obs_mv_cyc = -1; obs_we_cnt = 0; obs_we_cyc = -1;
    obs_mi = 0; obs_m1 = 0; obs_m2 = 0; obs_waddr = 0; obs_wdata = 0;
    obs_stall_ok = 1'b1; obs_stall_end = 1'b1;
    for (int cyc = 0; cyc < 40 && cyc <= end_cyc; cyc++) begin
      @(negedge clk);
      dec_valid       = (cyc == 0);
      dec_instruction = (cyc == 0) ? instr : $urandom;
      dec_rs1_val     = (cyc == 0) ? a : $urandom;
      dec_rs2_val     = (cyc == 0) ? b : $urandom;
      m_busy          = (cyc >= 1 && cyc <= busy_n);
      m_ready         = (mvc >= 0 && cyc == mvc + lat);
      m_rd            = m_ready ? res : $urandom;
      m_wr            = m_ready ? wr : 1'($urandom);
      flush           = flush_wait && mvc >= 0 && cyc == mvc + 1;
      #2;
      if (m_valid) begin
        obs_mv_cnt++;
        if (mvc < 0) begin
          mvc = cyc; obs_mv_cyc = cyc;
          obs_mi = m_instruction; obs_m1 = m_rs1; obs_m2 = m_rs2;
        end
      end
      if (m_ready) end_cyc = cyc + 2;
      if (rf_we) begin
        obs_we_cnt++; obs_we_cyc = cyc; obs_waddr = rf_waddr; obs_wdata = rf_wdata;
      end
      if (cyc < end_cyc) begin
        if (!stall) obs_stall_ok = 1'b0;
      end else begin
        obs_stall_end = stall;
      end
    end
    m_ready = 1'b0; flush = 1'b0;
    $display("op instr=%08h a=%08h b=%08h busy=%0d lat=%0d wr=%0b fl=%0b -> mv@%0d we=%0d@%0d rd=%0d data=%08h cnt=%0d",
             instr, a, b, busy_n, lat, wr, flush_wait, obs_mv_cyc, obs_we_cnt, obs_we_cyc,
             obs_waddr, obs_wdata, issued_cnt);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; dec_valid = 1'b0; flush = 1'b0; m_busy = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    #2;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({stall, m_valid, m_instruction, m_rs1, m_rs2, rf_we, rf_waddr, rf_wdata, err_timeout, issued_cnt} !== '0)
      $display("FAIL reset_outputs: got stall=%b mv=%b mi=%h rf_we=%b err=%b cnt=%0d, required all 0",
               stall, m_valid, m_instruction, rf_we, err_timeout, issued_cnt);
    else n_pass++;
  endtask

  task automatic test_mul();
    logic [31:0] ins;
    ins = enc(3'd0, 5'd5, OP_M);
    do_op(ins, 32'h1111FFFF, 32'h1111FFFF, 0, 3, 1'b1, 1'b0);
    exp_cnt++;
    n_checks++; if (obs_mv_cnt !== 1) $display("FAIL mul_mvalid_count: got %0d required 1", obs_mv_cnt); else n_pass++;
    n_checks++; if (obs_mv_cyc !== 1) $display("FAIL mul_mvalid_cycle: got %0d required 1", obs_mv_cyc); else n_pass++;
    n_checks++; if ({obs_mi, obs_m1, obs_m2} !== {ins, 32'h1111FFFF, 32'h1111FFFF})
      $display("FAIL mul_request: got %h/%h/%h", obs_mi, obs_m1, obs_m2); else n_pass++;
    n_checks++; if (obs_we_cnt !== 1) $display("FAIL mul_rfwe_count: got %0d required 1", obs_we_cnt); else n_pass++;
    n_checks++; if (obs_we_cyc !== 5) $display("FAIL mul_rfwe_cycle: got %0d required 5", obs_we_cyc); else n_pass++;
    n_checks++; if (obs_waddr !== 5'd5) $display("FAIL mul_waddr: got %0d required 5", obs_waddr); else n_pass++;
    n_checks++; if (obs_wdata !== 32'hDDDC0001) $display("FAIL mul_wdata: got %h required DDDC0001", obs_wdata); else n_pass++;
    n_checks++; if (obs_stall_ok !== 1'b1) $display("FAIL mul_stall_held: got %b required 1", obs_stall_ok); else n_pass++;
    n_checks++; if (obs_stall_end !== 1'b0) $display("FAIL mul_stall_release: got %b required 0", obs_stall_end); else n_pass++;
    n_checks++; if (issued_cnt !== CW'(exp_cnt)) $display("FAIL mul_issued_cnt: got %0d required %0d", issued_cnt, CW'(exp_cnt)); else n_pass++;
  endtask

  task automatic test_div_busy();
    do_op(enc(3'd4, 5'd7, OP_M), 32'hFFFFFFF3, 32'h0, 4, 2, 1'b1, 1'b0);
    exp_cnt++;
    n_checks++; if (obs_mv_cyc !== 5) $display("FAIL div_mvalid_after_busy: got cycle %0d required 5", obs_mv_cyc); else n_pass++;
    n_checks++; if (obs_mv_cnt !== 1) $display("FAIL div_mvalid_count: got %0d required 1", obs_mv_cnt); else n_pass++;
    n_checks++; if ({obs_we_cnt == 1, obs_waddr, obs_wdata} !== {1'b1, 5'd7, 32'hFFFFFFFF})
      $display("FAIL div_writeback: got we=%0d addr=%0d data=%h required 1/7/FFFFFFFF", obs_we_cnt, obs_waddr, obs_wdata); else n_pass++;
    n_checks++; if (obs_stall_ok !== 1'b1) $display("FAIL div_stall_held: got %b required 1", obs_stall_ok); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_op(enc(3'd3, 5'd9, OP_M), 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 1'b1, 1'b0);
    exp_cnt++;
    n_checks++; if ({obs_mv_cnt == 1, obs_waddr, obs_wdata} !== {1'b1, 5'd9, 32'hFFFFFFFE})
      $display("FAIL b2b_mulhu: got mv=%0d addr=%0d data=%h required 1/9/FFFFFFFE", obs_mv_cnt, obs_waddr, obs_wdata); else n_pass++;
    n_checks++; if (obs_we_cyc !== 3) $display("FAIL b2b_mulhu_latency: got %0d required 3", obs_we_cyc); else n_pass++;
    do_op(enc(3'd7, 5'd10, OP_M), 32'd13, 32'd5, 0, 2, 1'b1, 1'b0);
    exp_cnt++;
    n_checks++; if ({obs_mv_cnt == 1, obs_waddr, obs_wdata} !== {1'b1, 5'd10, 32'd3})
      $display("FAIL b2b_remu: got mv=%0d addr=%0d data=%h required 1/10/3", obs_mv_cnt, obs_waddr, obs_wdata); else n_pass++;
    n_checks++; if (issued_cnt !== CW'(exp_cnt)) $display("FAIL b2b_issued_cnt: got %0d required %0d", issued_cnt, CW'(exp_cnt)); else n_pass++;
  endtask

  task automatic test_flush();
    do_op(enc(3'd0, 5'd12, OP_CU), 32'd100, 32'd23, 0, 3, 1'b1, 1'b1);
    exp_cnt++;
    n_checks++; if (obs_mv_cnt !== 1) $display("FAIL flush_wait_mvalid: got %0d required 1", obs_mv_cnt); else n_pass++;
    n_checks++; if (obs_we_cnt !== 0) $display("FAIL flush_wait_rfwe: got %0d required 0", obs_we_cnt); else n_pass++;
    n_checks++; if ({obs_stall_ok, obs_stall_end} !== 2'b10) $display("FAIL flush_wait_stall: got %b%b required 10", obs_stall_ok, obs_stall_end); else n_pass++;
    do_op(enc(3'd1, 5'd13, OP_CU), 32'd100, 32'd23, 0, 2, 1'b1, 1'b0);
    exp_cnt++;
    n_checks++; if ({obs_we_cnt == 1, obs_waddr, obs_wdata} !== {1'b1, 5'd13, 32'd77})
      $display("FAIL flush_next_op: got we=%0d addr=%0d data=%h required 1/13/4d", obs_we_cnt, obs_waddr, obs_wdata); else n_pass++;
    do_op(enc(3'd0, 5'd0, OP_M), 32'd6, 32'd7, 0, 1, 1'b1, 1'b0);
    exp_cnt++;
    n_checks++; if ({obs_mv_cnt, obs_we_cnt} !== {32'd1, 32'd0}) $display("FAIL mul_x0: got mv=%0d we=%0d required 1/0", obs_mv_cnt, obs_we_cnt); else n_pass++;
    // Flush while held in ISSUE by m_busy: the request must never go out.
    @(negedge clk); dec_valid = 1'b1; dec_instruction = enc(3'd0, 5'd3, OP_M); m_busy = 1'b1; #2;
    @(negedge clk); dec_valid = 1'b0; flush = 1'b1; #2;
    n_checks++; if ({m_valid, stall} !== 2'b01) $display("FAIL flush_issue_cycle: got mv=%b stall=%b required 0/1", m_valid, stall); else n_pass++;
    @(negedge clk); flush = 1'b0; m_busy = 1'b0; #2;
    n_checks++; if ({m_valid, stall} !== 2'b00) $display("FAIL flush_issue_idle: got mv=%b stall=%b required 0/0", m_valid, stall); else n_pass++;
    @(negedge clk); #2;
    n_checks++; if (issued_cnt !== CW'(exp_cnt)) $display("FAIL flush_issue_cnt: got %0d required %0d", issued_cnt, CW'(exp_cnt)); else n_pass++;
  endtask

  task automatic test_ready_at_timeout();
    do_op(enc(3'd5, 5'd4, OP_M), 32'd1000, 32'd7, 0, TO, 1'b1, 1'b0);
    exp_cnt++;
    n_checks++; if ({obs_we_cnt == 1, obs_wdata} !== {1'b1, 32'd142})
      $display("FAIL ready_at_timeout_wb: got we=%0d data=%h required 1/8e", obs_we_cnt, obs_wdata); else n_pass++;
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL ready_at_timeout_err: got %b required 0", err_timeout); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] ins, a, b;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        wr, fl, exp_we;
    int          busy_n, lat;
    for (int i = 0; i < 20; i++) begin
      rd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) < 7) begin
        f3 = 3'($urandom_range(0, 7)); ins = enc(f3, rd, OP_M);
      end else begin
        f3 = 3'($urandom_range(0, 2)); ins = enc(f3, rd, OP_CU);
      end
      a = $urandom; b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      busy_n = $urandom_range(0, 3); lat = $urandom_range(1, 6);
      wr = ($urandom_range(0, 3) != 0); fl = ($urandom_range(0, 5) == 0);
      exp_we = wr && !fl && (rd != 5'd0);
      do_op(ins, a, b, busy_n, lat, wr, fl);
      exp_cnt++;
      n_checks++; if (obs_mv_cyc !== busy_n + 1) $display("FAIL rnd%0d_mvalid_cycle: got %0d required %0d", i, obs_mv_cyc, busy_n + 1); else n_pass++;
      n_checks++; if (obs_we_cnt !== int'(exp_we)) $display("FAIL rnd%0d_rfwe_count: got %0d required %0d", i, obs_we_cnt, exp_we); else n_pass++;
      if (exp_we) begin
        n_checks++;
        if ({obs_waddr, obs_wdata, obs_we_cyc} !== {rd, ref_unit(ins, a, b), busy_n + lat + 2})
          $display("FAIL rnd%0d_writeback: got %0d/%h@%0d required %0d/%h@%0d", i, obs_waddr, obs_wdata, obs_we_cyc,
                   rd, ref_unit(ins, a, b), busy_n + lat + 2);
        else n_pass++;
      end
      n_checks++; if ({obs_stall_ok, obs_stall_end} !== 2'b10) $display("FAIL rnd%0d_stall: got %b%b required 10", i, obs_stall_ok, obs_stall_end); else n_pass++;
      n_checks++; if (issued_cnt !== CW'(exp_cnt)) $display("FAIL rnd%0d_issued_cnt: got %0d required %0d", i, issued_cnt, CW'(exp_cnt)); else n_pass++;
    end
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL rnd_err: got %b required 0", err_timeout); else n_pass++;
  endtask

  task automatic test_timeout();
    int err_cyc, we_cnt;
    logic stall_before, stall_at_err;
    err_cyc = -1; we_cnt = 0; stall_before = 1'b0; stall_at_err = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      dec_valid = (cyc == 0); dec_instruction = enc(3'd0, 5'd8, OP_M);
      m_busy = 1'b0; m_ready = (cyc == 12); m_wr = 1'b1; m_rd = $urandom;
      #2;
      if (rf_we) we_cnt++;
      if (cyc == 9) stall_before = stall;
      if (err_timeout && err_cyc < 0) begin err_cyc = cyc; stall_at_err = stall; end
    end
    m_ready = 1'b0;
    exp_cnt++;
    $display("timeout op: err@%0d we=%0d cnt=%0d", err_cyc, we_cnt, issued_cnt);
    n_checks++; if (err_cyc !== 10) $display("FAIL timeout_err_cycle: got %0d required 10", err_cyc); else n_pass++;
    n_checks++; if ({stall_before, stall_at_err} !== 2'b10) $display("FAIL timeout_stall: got %b%b required 10", stall_before, stall_at_err); else n_pass++;
    n_checks++; if (we_cnt !== 0) $display("FAIL timeout_rfwe: got %0d required 0", we_cnt); else n_pass++;
    n_checks++; if (err_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b required 1", err_timeout); else n_pass++;
    n_checks++; if (issued_cnt !== CW'(exp_cnt)) $display("FAIL timeout_issued_cnt: got %0d required %0d", issued_cnt, CW'(exp_cnt)); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] bad [3];
    int ign;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      dec_valid = (cyc == 0); dec_instruction = enc(3'd0, 5'd6, OP_M);
      dec_rs1_val = 32'd3; dec_rs2_val = 32'd4; #2;
    end
    @(negedge clk); reset = 1'b1; #2;
    @(negedge clk); reset = 1'b0; exp_cnt = 0; #2;
    n_checks++;
    if ({stall, m_valid, m_instruction, m_rs1, m_rs2, rf_we, rf_waddr, rf_wdata, err_timeout, issued_cnt} !== '0)
      $display("FAIL midwait_reset_outputs: got stall=%b mv=%b mi=%h rf_we=%b err=%b cnt=%0d, required all 0",
               stall, m_valid, m_instruction, rf_we, err_timeout, issued_cnt);
    else n_pass++;
    ign = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk); m_ready = (cyc == 0); m_wr = 1'b1; m_rd = 32'hABCD1234; #2;
      if (rf_we || m_valid || stall) ign++;
    end
    m_ready = 1'b0;
    n_checks++; if (ign !== 0) $display("FAIL stale_ready_ignored: got %0d active cycles required 0", ign); else n_pass++;
    do_op(enc(3'd2, 5'd14, OP_CU), 32'd100000, 32'd0, 1, 2, 1'b1, 1'b0);
    exp_cnt++;
    n_checks++; if ({obs_we_cnt == 1, obs_waddr, obs_wdata} !== {1'b1, 5'd14, 32'd130})
      $display("FAIL modq_after_reset: got we=%0d addr=%0d data=%h required 1/14/82", obs_we_cnt, obs_waddr, obs_wdata); else n_pass++;
    n_checks++; if (issued_cnt !== CW'(exp_cnt)) $display("FAIL modq_issued_cnt: got %0d required %0d", issued_cnt, CW'(exp_cnt)); else n_pass++;
    // Non-matching words: ADDI, OP with funct7=0, custom-0 with unused funct3.
    bad[0] = {7'b0000001, 5'd2, 5'd1, 3'd0, 5'd5, 7'h13};
    bad[1] = {7'b0000000, 5'd2, 5'd1, 3'd0, 5'd5, OP_M};
    bad[2] = enc(3'd7, 5'd5, OP_CU);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); dec_valid = 1'b1; dec_instruction = bad[i]; #2;
      n_checks++; if (stall !== 1'b0) $display("FAIL nonmatch%0d_stall: got %b required 0", i, stall); else n_pass++;
      @(negedge clk); dec_valid = 1'b0; #2;
      n_checks++; if ({m_valid, stall} !== 2'b00) $display("FAIL nonmatch%0d_issue: got mv=%b stall=%b required 0/0", i, m_valid, stall); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; dec_valid = 1'b0; dec_instruction = '0; dec_rs1_val = '0; dec_rs2_val = '0;
    flush = 1'b0; m_wr = 1'b0; m_rd = '0; m_busy = 1'b0; m_ready = 1'b0;
    test_reset();
    test_mul();
    test_div_busy();
    test_back_to_back();
    test_flush();
    test_ready_at_timeout();
    test_random();
    test_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
